// File: rtl/sobel_window_gen_pkg.sv
// rtl/sobel_window_gen_pkg.sv - shared constants, FSM states and window index helper
package sobel_window_gen_pkg;

    localparam int VGA_HACT  = 640;
    localparam int VGA_VACT  = 480;
    localparam int DEF_PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Element k of the packed window; y=0 is the oldest row, x=0 the oldest column.
    function automatic int win_idx(input int y, input int x);
        return 3 * y + x;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - two line buffers stored side by side, 1-cycle synchronous read
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16,
    parameter int AW    = 10
) (
    input  logic             clk_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Contents are never cleared: the FILL phase rewrites every word before it is used.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - builds 3x3 pixel windows from a raster stream for the sobel stage
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int H_ACT = VGA_HACT,
    parameter int V_ACT = VGA_VACT,
    parameter int PIX_W = DEF_PIX_W,
    parameter int CW    = $clog2(H_ACT),
    parameter int RW    = $clog2(V_ACT)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [CW-1:0]      pixel_col_i,
    input  logic [RW-1:0]      pixel_row_i,
    input  logic [PIX_W-1:0]   pixel_i,
    input  logic               pixel_write_enable_i,
    output logic [9*PIX_W-1:0] window_o,
    output logic [CW-1:0]      center_col_o,
    output logic [RW-1:0]      center_row_o,
    output logic               window_valid_o,
    output logic               frame_done_o,
    output logic               sync_err_o
);

    localparam logic [CW-1:0] COL_LAST = CW'(H_ACT - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_ACT - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     exp_col_q, exp_col_d;
    logic [RW-1:0]     exp_row_q, exp_row_d;
    logic              accept, upd, emit, err, last;

    logic              s1_upd_q, s1_emit_q, s1_done_q, s1_err_q;
    logic [CW-1:0]     s1_col_q;
    logic [RW-1:0]     s1_row_q;
    logic [PIX_W-1:0]  s1_pix_q;
    logic [2*PIX_W-1:0] lb_rd;
    logic [2:0][PIX_W-1:0] new_col;
    logic [8:0][PIX_W-1:0] window_q, window_d;

    logic              s2_emit_q, s2_done_q, s2_err_q;
    logic [CW-1:0]     s2_col_q;
    logic [RW-1:0]     s2_row_q;

    logic [9*PIX_W-1:0] out_window_q;
    logic [CW-1:0]     out_col_q;
    logic [RW-1:0]     out_row_q;
    logic              out_valid_q, out_done_q, out_err_q;

    assign accept = enable_i & pixel_write_enable_i;

    // Stage 0: sequence tracking; only accepted pixels move the FSM.
    always_comb begin
        state_d   = state_q;
        exp_col_d = exp_col_q;
        exp_row_d = exp_row_q;
        upd       = 1'b0;
        emit      = 1'b0;
        err       = 1'b0;
        last      = 1'b0;
        if (accept) begin
            if (pixel_col_i == '0 && pixel_row_i == '0) begin
                state_d = ST_FILL;
                upd     = 1'b1;
            end else if (state_q != ST_IDLE) begin
                if (pixel_col_i == exp_col_q && pixel_row_i == exp_row_q) begin
                    upd  = 1'b1;
                    last = (pixel_row_i == ROW_LAST) && (pixel_col_i == COL_LAST);
                    emit = (state_q == ST_STREAM) && (pixel_row_i >= RW'(2)) && (pixel_col_i >= CW'(2));
                    if (state_q == ST_FILL && pixel_row_i == RW'(2) && pixel_col_i == '0) begin
                        state_d = ST_STREAM;
                    end
                    if (last) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            if (upd) begin
                if (pixel_col_i == COL_LAST) begin
                    exp_col_d = '0;
                    exp_row_d = pixel_row_i + RW'(1);
                end else begin
                    exp_col_d = pixel_col_i + CW'(1);
                    exp_row_d = pixel_row_i;
                end
            end
        end
    end

    sobel_line_buffer #(
        .DEPTH (H_ACT),
        .WIDTH (2 * PIX_W),
        .AW    (CW)
    ) u_line_buffer (
        .clk_i     (clk_i),
        .rd_addr_i (pixel_col_i),
        .rd_data_o (lb_rd),
        .wr_en_i   (s1_upd_q),
        .wr_addr_i (s1_col_q),
        .wr_data_i ({lb_rd[PIX_W-1:0], s1_pix_q})
    );

    // Stage 1: new column is {row r-2, row r-1, row r} from top to bottom.
    always_comb begin
        new_col[0] = lb_rd[2*PIX_W-1:PIX_W];
        new_col[1] = lb_rd[PIX_W-1:0];
        new_col[2] = s1_pix_q;
        window_d   = window_q;
        if (s1_upd_q) begin
            for (int y = 0; y < 3; y++) begin
                window_d[win_idx(y, 0)] = window_q[win_idx(y, 1)];
                window_d[win_idx(y, 1)] = window_q[win_idx(y, 2)];
                window_d[win_idx(y, 2)] = new_col[y];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            exp_col_q    <= '0;
            exp_row_q    <= '0;
            s1_upd_q     <= 1'b0;
            s1_emit_q    <= 1'b0;
            s1_done_q    <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_col_q     <= '0;
            s1_row_q     <= '0;
            s1_pix_q     <= '0;
            window_q     <= '0;
            s2_emit_q    <= 1'b0;
            s2_done_q    <= 1'b0;
            s2_err_q     <= 1'b0;
            s2_col_q     <= '0;
            s2_row_q     <= '0;
            out_window_q <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            out_valid_q  <= 1'b0;
            out_done_q   <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_col_q <= exp_col_d;
            exp_row_q <= exp_row_d;
            s1_upd_q  <= upd;
            s1_emit_q <= emit;
            s1_done_q <= emit & last;
            s1_err_q  <= err;
            s1_col_q  <= pixel_col_i;
            s1_row_q  <= pixel_row_i;
            s1_pix_q  <= pixel_i;
            window_q  <= window_d;
            s2_emit_q <= s1_emit_q;
            s2_done_q <= s1_done_q;
            s2_err_q  <= s1_err_q;
            s2_col_q  <= s1_col_q - CW'(1);
            s2_row_q  <= s1_row_q - RW'(1);
            out_valid_q <= s2_emit_q;
            out_done_q  <= s2_done_q;
            out_err_q   <= s2_err_q;
            if (s2_emit_q) begin
                out_window_q <= window_q;
                out_col_q    <= s2_col_q;
                out_row_q    <= s2_row_q;
            end
        end
    end

    assign window_o       = out_window_q;
    assign center_col_o   = out_col_q;
    assign center_row_o   = out_row_q;
    assign window_valid_o = out_valid_q;
    assign frame_done_o   = out_done_q;
    assign sync_err_o     = out_err_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - directed self-checking bench for sobel_window_gen on an 8x4 frame
module tb_sobel_window_gen;

    localparam int H = 8;
    localparam int V = 4;

    typedef struct {
        int         row;
        int         col;
        logic [71:0] win;
        bit         done;
        int         cyc;
    } win_t;

    typedef struct {
        string name;
        int    gap;
        int    blank;
        int    seed;
        bit    en;
        int    exp_windows;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, enable, we;
    logic [2:0]  col;
    logic [1:0]  row;
    logic [7:0]  pix;
    logic [71:0] window;
    logic [2:0]  ccol;
    logic [1:0]  crow;
    logic        wv, fd, se;

    win_t got[$];
    win_t exp_q[$];
    vec_t vecs[4];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   err_cnt = 0;
    int   done_cnt = 0;
    int   err_cyc = 0;
    int   last_acc = 0;
    int   err_acc = 0;

    sobel_window_gen #(.H_ACT(H), .V_ACT(V), .PIX_W(8)) dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .enable_i             (enable),
        .pixel_col_i          (col),
        .pixel_row_i          (row),
        .pixel_i              (pix),
        .pixel_write_enable_i (we),
        .window_o             (window),
        .center_col_o         (ccol),
        .center_row_o         (crow),
        .window_valid_o       (wv),
        .frame_done_o         (fd),
        .sync_err_o           (se)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wv) got.push_back('{int'(crow), int'(ccol), window, fd, cyc});
        if (fd) done_cnt++;
        if (se) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    function automatic logic [7:0] pix_of(int r, int c, int seed);
        return 8'((r * 16 + c + seed) & 255);
    endfunction

    function automatic logic [71:0] model_win(int cr, int cc, int seed);
        logic [71:0] w;
        w = '0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                w[8*(3*y+x) +: 8] = pix_of(cr - 1 + y, cc - 1 + x, seed);
        return w;
    endfunction

    task automatic chk(string name, logic [71:0] act, logic [71:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(int r, int c, bit en, bit expct, int seed);
        logic [31:0] rv, cv;
        rv = r;
        cv = c;
        enable = en;
        we     = 1'b1;
        row    = rv[1:0];
        col    = cv[2:0];
        pix    = pix_of(r, c, seed);
        last_acc = cyc + 1;
        if (expct)
            exp_q.push_back('{r - 1, c - 1, model_win(r - 1, c - 1, seed),
                              (r == V - 1 && c == H - 1), cyc + 3});
        @(negedge clk);
        we     = 1'b0;
        enable = 1'b1;
    endtask

    task automatic frame(int seed, int gap, int blank, bit en);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                send(r, c, en, en && r >= 2 && c >= 2, seed);
                idle(gap);
            end
            idle(blank);
        end
    endtask

    task automatic check_seg(string name, int exp_err);
        int n_done;
        idle(6);
        n_done = 0;
        foreach (exp_q[i]) if (exp_q[i].done) n_done++;
        chk($sformatf("%s count", name), got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s w%0d row", name, i), got[i].row, exp_q[i].row);
            chk($sformatf("%s w%0d col", name, i), got[i].col, exp_q[i].col);
            chk($sformatf("%s w%0d data", name, i), got[i].win, exp_q[i].win);
            chk($sformatf("%s w%0d done", name, i), got[i].done, exp_q[i].done);
            chk($sformatf("%s w%0d cycle", name, i), got[i].cyc, exp_q[i].cyc);
        end
        chk($sformatf("%s sync_err pulses", name), err_cnt, exp_err);
        chk($sformatf("%s frame_done pulses", name), done_cnt, n_done);
        got.delete();
        exp_q.delete();
        err_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic check_zero(string name);
        chk({name, " valid"}, wv, 0);
        chk({name, " window"}, window, 0);
        chk({name, " ccol"}, ccol, 0);
        chk({name, " crow"}, crow, 0);
        chk({name, " done"}, fd, 0);
        chk({name, " err"}, se, 0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; we = 1'b0; row = '0; col = '0; pix = '0;
        vecs[0] = '{"b2b",   0, 0, 0,     1'b1, 12};
        vecs[1] = '{"gaps",  3, 5, 0,     1'b1, 12};
        vecs[2] = '{"en_off", 0, 0, 9,    1'b0, 0};
        vecs[3] = '{"seeded", 1, 2, 8'h5a, 1'b1, 12};

        idle(3);
        check_zero("reset");
        reset = 1'b0;
        enable = 1'b1;
        idle(2);

        for (int i = 0; i < 4; i++) begin
            frame(vecs[i].seed, vecs[i].gap, vecs[i].blank, vecs[i].en);
            if (i == 0 && got.size() > 0) begin
                chk("first window data", got[0].win, 72'h22_21_20_12_11_10_02_01_00);
                chk("first window row", got[0].row, 1);
                chk("first window col", got[0].col, 1);
            end
            idle(6);
            chk($sformatf("%s table count", vecs[i].name), got.size(), vecs[i].exp_windows);
            check_seg(vecs[i].name, 0);
        end

        // Skipped pixel (2,5): one error, then nothing until the next frame start.
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if (r == 2 && c == 5) continue;
                send(r, c, 1'b1, r == 2 && c >= 2 && c <= 4, 3);
                if (r == 2 && c == 6) err_acc = last_acc;
            end
        end
        check_seg("skip", 1);
        chk("skip err timing", err_cyc, err_acc + 2);
        frame(8'h21, 0, 0, 1'b1);
        check_seg("after skip", 0);

        // Frame restart mid row 3: no error, new frame clean.
        for (int r = 0; r < V; r++)
            for (int c = 0; c < ((r == 3) ? 4 : H); c++)
                send(r, c, 1'b1, r >= 2 && c >= 2, 8'h30);
        frame(8'h77, 0, 0, 1'b1);
        check_seg("resync", 0);

        // Reset while windows for (2,2) and (2,3) are in flight.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < ((r == 2) ? 4 : H); c++)
                send(r, c, 1'b1, 1'b0, 8'h44);
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid reset");
        idle(1);
        reset = 1'b0;
        check_seg("reset inflight", 0);
        frame(8'h13, 0, 0, 1'b1);
        check_seg("after reset", 0);

        // Enable drops the cycle after the last accept; its window still emits.
        frame(8'h66, 0, 0, 1'b1);
        send(1, 3, 1'b0, 1'b0, 8'h66);
        check_seg("enable drop", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
